// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM buffer family.
//  - default WIDTH/DEPTH/LANES values shared with the other buffers
//  - f_wrap: fold an address that is below 2*depth back into [0, depth)
//  - SRAM_LANE: select lane k of a packed multi-lane data bus
`ifndef SRAM_PKG_SV
`define SRAM_PKG_SV
`define SRAM_LANE(v, k, w) v[(k)*(w) +: (w)]

package sram_pkg;
  localparam int SRAM_WIDTH = 10;
  localparam int SRAM_DEPTH = 128;
  localparam int SRAM_LANES = 4;

  // Callers guarantee addr < 2*depth, so one conditional subtract is enough.
  function automatic logic [31:0] f_wrap(input logic [31:0] addr, input logic [31:0] depth);
    return (addr >= depth) ? (addr - depth) : addr;
  endfunction
endpackage
`endif

// File: rtl/ml_sram_addr_gen.sv
// Per-lane write address generator for ml_sram (combinational).
//  base_i      write base address
//  mask_i      per-lane write mask
//  lane_addr_o lane k target address (wrapped when WRAP=1)
//  lane_we_o   lane k actually writes (masked in and in range)
//  drop_o      a masked-in lane was dropped because it is out of range
module ml_sram_addr_gen
  import sram_pkg::*;
#(
  parameter int DEPTH = SRAM_DEPTH,
  parameter int LANES = SRAM_LANES,
  parameter int ADDRB = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int WRAP  = 1
) (
  input  logic [ADDRB-1:0]            base_i,
  input  logic [LANES-1:0]            mask_i,
  output logic [LANES-1:0][ADDRB-1:0] lane_addr_o,
  output logic [LANES-1:0]            lane_we_o,
  output logic                        drop_o
);
  localparam logic [ADDRB:0] DEPTH_X = (ADDRB+1)'(DEPTH);

  logic             base_ok;
  logic [LANES-1:0] drop_v;

  assign base_ok = {1'b0, base_i} < DEPTH_X;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    // One extra bit so base+k is range-tested before any truncation.
    logic [ADDRB:0] sum;
    assign sum = {1'b0, base_i} + (ADDRB+1)'(k);

    if (WRAP != 0) begin : g_wrap
      assign lane_addr_o[k] = ADDRB'(f_wrap(32'(sum), 32'(DEPTH)));
      assign lane_we_o[k]   = mask_i[k] & base_ok;
      // A bad base drops the whole beat; report it once via lane 0's slot.
      assign drop_v[k]      = (k == 0) ? (~base_ok & (|mask_i)) : 1'b0;
    end else begin : g_clip
      assign lane_addr_o[k] = sum[ADDRB-1:0];
      assign lane_we_o[k]   = mask_i[k] & (sum < DEPTH_X);
      assign drop_v[k]      = mask_i[k] & ~(sum < DEPTH_X);
    end
  end

  assign drop_o = |drop_v;
endmodule

// File: rtl/ml_sram.sv
// Multi-lane write / single read SRAM buffer.
//  i_clk, i_rst   clock, async active-high reset
//  i_en           global enable for reads, writes and pointer updates
//  i_we, i_wauto  write request; base = wptr (i_wauto=1) or i_waddr
//  i_wptr_ld      load wptr from i_waddr (wins over auto advance)
//  i_lane_mask    per-lane write enable
//  i_wdata        lane k at [k*WIDTH +: WIDTH]
//  i_re, i_raddr  read request / address
//  o_rdata        registered read data, o_rvalid marks a fresh read
//  o_wr_err       dropped lane or clamped pointer load
//  o_rd_err       read address out of range
//  o_wptr         auto-write pointer
module ml_sram
  import sram_pkg::*;
#(
  parameter int WIDTH     = SRAM_WIDTH,
  parameter int DEPTH     = SRAM_DEPTH,
  parameter int LANES     = SRAM_LANES,
  parameter int ADDRB     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int WRAP      = 1,
  parameter int RD_BYPASS = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_we,
  input  logic                   i_wauto,
  input  logic                   i_wptr_ld,
  input  logic [ADDRB-1:0]       i_waddr,
  input  logic [LANES-1:0]       i_lane_mask,
  input  logic [LANES*WIDTH-1:0] i_wdata,
  input  logic                   i_re,
  input  logic [ADDRB-1:0]       i_raddr,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_rvalid,
  output logic                   o_wr_err,
  output logic                   o_rd_err,
  output logic [ADDRB-1:0]       o_wptr
);
  localparam int             MB      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRB:0] DEPTH_X = (ADDRB+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [ADDRB-1:0]            wptr_q, wptr_d, base;
  logic [WIDTH-1:0]            rdata_q, rdata_d;
  logic                        rvalid_q, wr_err_q, rd_err_q;
  logic                        first_q;  // first edge after reset: reads are discarded
  logic [LANES-1:0][ADDRB-1:0] lane_addr;
  logic [LANES-1:0]            lane_we;
  logic                        drop, rd_ok, ld_ok, byp_hit;
  logic [WIDTH-1:0]            byp_data;

  assign base  = i_wauto ? wptr_q : i_waddr;
  assign rd_ok = {1'b0, i_raddr} < DEPTH_X;
  assign ld_ok = {1'b0, i_waddr} < DEPTH_X;

  ml_sram_addr_gen #(
    .DEPTH(DEPTH), .LANES(LANES), .ADDRB(ADDRB), .WRAP(WRAP)
  ) u_agen (
    .base_i     (base),
    .mask_i     (i_lane_mask),
    .lane_addr_o(lane_addr),
    .lane_we_o  (lane_we),
    .drop_o     (drop)
  );

  // Memory is not reset.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_we[k]) mem[lane_addr[k][MB-1:0]] <= `SRAM_LANE(i_wdata, k, WIDTH);
      end
    end
  end

  // Lane addresses in a beat are distinct, so at most one lane can hit.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_we && lane_we[k] && (lane_addr[k] == i_raddr)) begin
        byp_hit  = 1'b1;
        byp_data = `SRAM_LANE(i_wdata, k, WIDTH);
      end
    end
  end

  assign rdata_d = ((RD_BYPASS != 0) && byp_hit) ? byp_data : mem[i_raddr[MB-1:0]];
  assign wptr_d  = ADDRB'(f_wrap(32'(wptr_q) + 32'(LANES), 32'(DEPTH)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
      wptr_q   <= '0;
      first_q  <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
      first_q  <= 1'b0;
      if (i_en) begin
        wr_err_q <= (i_we & drop) | (i_wptr_ld & ~ld_ok);
        if (i_wptr_ld)               wptr_q <= ld_ok ? i_waddr : '0;
        else if (i_we && i_wauto)    wptr_q <= wptr_d;
        if (i_re && !first_q) begin
          if (rd_ok) begin
            rdata_q  <= rdata_d;
            rvalid_q <= 1'b1;
          end else begin
            rd_err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign o_rdata  = rdata_q;
  assign o_rvalid = rvalid_q;
  assign o_wr_err = wr_err_q;
  assign o_rd_err = rd_err_q;
  assign o_wptr   = wptr_q;
endmodule
